// File: rtl/sobel_window_ctrl_if.sv
// sobel_window_ctrl_if
//   Groups the pixel stream, the 3x3 window handed to the Sobel core, the
//   edge value returned by the core and the aligned output stream.
//   Ports (signals):
//     pix_in[7:0], pix_valid, frame_start : raster pixel stream into the controller
//     z0..z8[7:0], win_valid, border      : window towards the Sobel core
//     edge_in[7:0]                        : edge value returned by the core
//     out_valid, out_pixel[7:0],
//     out_x[CW-1:0], out_y[CW-1:0]        : edge result aligned with its coordinates
//   Modports: slave = the controller, master = the environment around it.
interface sobel_window_ctrl_if #(
  parameter int CW = 10
);
  logic [7:0]    pix_in;
  logic          pix_valid;
  logic          frame_start;
  logic [7:0]    z0, z1, z2, z3, z4, z5, z6, z7, z8;
  logic          win_valid;
  logic          border;
  logic [7:0]    edge_in;
  logic          out_valid;
  logic [7:0]    out_pixel;
  logic [CW-1:0] out_x;
  logic [CW-1:0] out_y;

  modport slave (
    input  pix_in, pix_valid, frame_start, edge_in,
    output z0, z1, z2, z3, z4, z5, z6, z7, z8, win_valid, border,
    output out_valid, out_pixel, out_x, out_y
  );

  modport master (
    output pix_in, pix_valid, frame_start, edge_in,
    input  z0, z1, z2, z3, z4, z5, z6, z7, z8, win_valid, border,
    input  out_valid, out_pixel, out_x, out_y
  );
endinterface

// File: rtl/sobel_window_ctrl.sv
// sobel_window_ctrl
//   Builds the sliding 3x3 window for a Sobel edge core from a raster pixel
//   stream using two line buffers, and delays the window's valid/border/
//   coordinate tags by the core latency so they line up with the returned
//   edge value. Windows touching the first two rows or columns are output as
//   8'hff (no edge).
//   Ports:
//     clock   : system clock
//     reset_n : synchronous active-low reset
//     bus     : sobel_window_ctrl_if.slave (pixel stream in, window out,
//               edge_in from the core, aligned out_* stream)
module sobel_window_ctrl #(
  parameter int WIDTH     = 640,
  parameter int SOBEL_LAT = 3,
  parameter int CW        = 10
) (
  input  logic               clock,
  input  logic               reset_n,
  sobel_window_ctrl_if.slave bus
);
  localparam int            AW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
  localparam logic [CW-1:0] MAX_ROW  = {CW{1'b1}};

  // lb1 holds row r-1, lb0 holds row r-2; never cleared, border masking
  // hides whatever stale data they contain at the start of a frame.
  logic [7:0] lb0_mem [WIDTH];
  logic [7:0] lb1_mem [WIDTH];

  logic [7:0]    win_q [9];
  logic [7:0]    win_d [9];
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          border_q, border_d;
  logic [CW-1:0] win_x_q, win_x_d;
  logic [CW-1:0] win_y_q, win_y_d;

  logic          dl_valid_q  [SOBEL_LAT];
  logic          dl_valid_d  [SOBEL_LAT];
  logic          dl_border_q [SOBEL_LAT];
  logic          dl_border_d [SOBEL_LAT];
  logic [CW-1:0] dl_x_q      [SOBEL_LAT];
  logic [CW-1:0] dl_x_d      [SOBEL_LAT];
  logic [CW-1:0] dl_y_q      [SOBEL_LAT];
  logic [CW-1:0] dl_y_d      [SOBEL_LAT];

  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_pixel_q, out_pixel_d;
  logic [CW-1:0] out_x_q, out_x_d;
  logic [CW-1:0] out_y_q, out_y_d;

  logic          accept;
  logic [CW-1:0] cur_c;
  logic [CW-1:0] cur_r;
  logic [AW-1:0] lb_addr;
  logic [7:0]    lb0_rd;
  logic [7:0]    lb1_rd;

  // frame_start only counts when the pixel is accepted; it forces (0,0).
  assign accept  = bus.pix_valid;
  assign cur_c   = (bus.pix_valid && bus.frame_start) ? '0 : col_q;
  assign cur_r   = (bus.pix_valid && bus.frame_start) ? '0 : row_q;
  assign lb_addr = cur_c[AW-1:0];
  assign lb0_rd  = lb0_mem[lb_addr];
  assign lb1_rd  = lb1_mem[lb_addr];

  // Read-before-write: the combinational reads above see the old column
  // contents, so lb0 inherits lb1's old value while lb1 takes the new pixel.
  always_ff @(posedge clock) begin
    if (reset_n && accept) begin
      lb0_mem[lb_addr] <= lb1_rd;
      lb1_mem[lb_addr] <= bus.pix_in;
    end
  end

  // Window shift, border flag and raster counters.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      win_d[i] = win_q[i];
    end
    col_d       = col_q;
    row_d       = row_q;
    win_x_d     = win_x_q;
    win_y_d     = win_y_q;
    border_d    = border_q;
    win_valid_d = 1'b0;
    if (accept) begin
      for (int k = 0; k < 3; k++) begin
        win_d[3*k]     = win_q[3*k + 1];
        win_d[3*k + 1] = win_q[3*k + 2];
      end
      win_d[2]    = lb0_rd;
      win_d[5]    = lb1_rd;
      win_d[8]    = bus.pix_in;
      win_valid_d = 1'b1;
      border_d    = (cur_r < CW'(2)) || (cur_c < CW'(2));
      win_x_d     = cur_c;
      win_y_d     = cur_r;
      if (cur_c == LAST_COL) begin
        col_d = '0;
        row_d = (cur_r == MAX_ROW) ? cur_r : cur_r + CW'(1);
      end else begin
        col_d = cur_c + CW'(1);
        row_d = cur_r;
      end
    end
  end

  // Tag delay line: advances every cycle so gaps keep their spacing and the
  // tap lines up with the free-running core's edge_in.
  assign dl_valid_d[0]  = win_valid_q;
  assign dl_border_d[0] = border_q;
  assign dl_x_d[0]      = win_x_q;
  assign dl_y_d[0]      = win_y_q;

  generate
    for (genvar gi = 1; gi < SOBEL_LAT; gi++) begin : g_dl
      assign dl_valid_d[gi]  = dl_valid_q[gi-1];
      assign dl_border_d[gi] = dl_border_q[gi-1];
      assign dl_x_d[gi]      = dl_x_q[gi-1];
      assign dl_y_d[gi]      = dl_y_q[gi-1];
    end
  endgenerate

  always_comb begin
    out_valid_d = dl_valid_q[SOBEL_LAT-1];
    out_x_d     = dl_x_q[SOBEL_LAT-1];
    out_y_d     = dl_y_q[SOBEL_LAT-1];
    out_pixel_d = dl_border_q[SOBEL_LAT-1] ? 8'hff : bus.edge_in;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= '0;
      end
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      border_q    <= 1'b0;
      win_x_q     <= '0;
      win_y_q     <= '0;
      for (int i = 0; i < SOBEL_LAT; i++) begin
        dl_valid_q[i]  <= 1'b0;
        dl_border_q[i] <= 1'b0;
        dl_x_q[i]      <= '0;
        dl_y_q[i]      <= '0;
      end
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= win_d[i];
      end
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      border_q    <= border_d;
      win_x_q     <= win_x_d;
      win_y_q     <= win_y_d;
      for (int i = 0; i < SOBEL_LAT; i++) begin
        dl_valid_q[i]  <= dl_valid_d[i];
        dl_border_q[i] <= dl_border_d[i];
        dl_x_q[i]      <= dl_x_d[i];
        dl_y_q[i]      <= dl_y_d[i];
      end
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
    end
  end

  assign bus.z0        = win_q[0];
  assign bus.z1        = win_q[1];
  assign bus.z2        = win_q[2];
  assign bus.z3        = win_q[3];
  assign bus.z4        = win_q[4];
  assign bus.z5        = win_q[5];
  assign bus.z6        = win_q[6];
  assign bus.z7        = win_q[7];
  assign bus.z8        = win_q[8];
  assign bus.win_valid = win_valid_q;
  assign bus.border    = border_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_pixel = out_pixel_q;
  assign bus.out_x     = out_x_q;
  assign bus.out_y     = out_y_q;
endmodule

// File: tb/tb_sobel_window_ctrl.sv
// tb_sobel_window_ctrl
//   Drives sobel_window_ctrl (WIDTH=8) with directed and randomized raster
//   streams, closes the loop with a 3-stage Sobel core model, and checks the
//   window, border flag and aligned output stream against an image-level
//   reference model.
`timescale 1ns/1ps
module tb_sobel_window_ctrl;
  localparam int W   = 8;
  localparam int LAT = 3;
  localparam int CW  = 10;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  sobel_window_ctrl_if #(.CW(CW)) bus ();

  sobel_window_ctrl #(.WIDTH(W), .SOBEL_LAT(LAT), .CW(CW)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Edge value: 255 - |Gx| - |Gy|, clamped to 0 (flat areas read white).
  function automatic logic [7:0] sob(input int a0, input int a1, input int a2,
                                     input int a3, input int a4, input int a5,
                                     input int a6, input int a7, input int a8);
    int gx, gy, mag;
    gx  = (a2 + 2*a5 + a8) - (a0 + 2*a3 + a6);
    gy  = (a6 + 2*a7 + a8) - (a0 + 2*a1 + a2);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy) + 0*a4;
    return (mag > 255) ? 8'h00 : 8'(255 - mag);
  endfunction

  // Free-running Sobel core with a 3-edge latency.
  logic [7:0] cs0, cs1, cs2;
  always @(posedge clock) begin
    cs0 <= sob(int'(bus.z0), int'(bus.z1), int'(bus.z2), int'(bus.z3), int'(bus.z4),
               int'(bus.z5), int'(bus.z6), int'(bus.z7), int'(bus.z8));
    cs1 <= cs0;
    cs2 <= cs1;
  end
  assign bus.edge_in = cs2;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] px;
    int         acc;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [7:0] log_q[$];
  logic [7:0] saved[$];
  int         nout = 0;
  int         ref_col = 0;
  int         ref_row = 0;
  logic [7:0] img [0:63][0:W-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] zget(input int k);
    case (k)
      0: return bus.z0;
      1: return bus.z1;
      2: return bus.z2;
      3: return bus.z3;
      4: return bus.z4;
      5: return bus.z5;
      6: return bus.z6;
      7: return bus.z7;
      default: return bus.z8;
    endcase
  endfunction

  // Output monitor: every out_valid must match the oldest expected pixel,
  // exactly LAT+1 edges after it was accepted.
  always @(negedge clock) begin
    if (bus.out_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("out_x", 32'(bus.out_x), 32'(mon_e.x));
        chk("out_y", 32'(bus.out_y), 32'(mon_e.y));
        chk("out_pixel", 32'(bus.out_pixel), 32'(mon_e.px));
        chk("latency", 32'(cyc - mon_e.acc), 32'(LAT + 1));
        log_q.push_back(bus.out_pixel);
        nout++;
      end
    end else if (q.size() > 0 && (cyc - q[0].acc) > LAT + 1) begin
      chk("missing_out_valid", 32'd0, 32'd1);
      mon_e = q.pop_front();
    end
  end

  // Reference model for one accepted pixel, evaluated just after its edge.
  task automatic model_accept(input logic [7:0] px, input bit fs);
    int         c, r;
    bit         bord;
    logic [7:0] ev;
    int         w[9];
    exp_t       e;
    c = fs ? 0 : ref_col;
    r = fs ? 0 : ref_row;
    img[r][c] = px;
    bord = (r < 2) || (c < 2);
    ev = 8'hff;
    if (!bord) begin
      for (int k = 0; k < 9; k++) w[k] = int'(img[r - 2 + k/3][c - 2 + k%3]);
      ev = sob(w[0], w[1], w[2], w[3], w[4], w[5], w[6], w[7], w[8]);
    end
    e.x = c; e.y = r; e.px = ev; e.acc = cyc;
    q.push_back(e);
    chk("win_valid", 32'(bus.win_valid), 32'd1);
    chk("border", 32'(bus.border), 32'(bord));
    if (!bord) begin
      for (int k = 0; k < 9; k++)
        chk($sformatf("z%0d", k), 32'(zget(k)), 32'(w[k]));
    end
    if (c == W - 1) begin
      ref_col = 0;
      ref_row = r + 1;
    end else begin
      ref_col = c + 1;
      ref_row = r;
    end
  endtask

  task automatic send(input logic [7:0] px, input bit fs);
    bus.pix_in      = px;
    bus.pix_valid   = 1'b1;
    bus.frame_start = fs;
    @(posedge clock); #1;
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    model_accept(px, fs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock); #1;
      chk("win_valid_idle", 32'(bus.win_valid), 32'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_timeout", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_in      = 8'd0;
    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;

    // 1. Reset with pix_valid toggling, then a flat 4-row frame.
    reset_n = 1'b0;
    bus.pix_in = 8'(($urandom) & 8'hff);
    bus.pix_valid = 1'b1;
    @(posedge clock); #1;
    bus.pix_valid = 1'b0;
    @(posedge clock); #1;
    chk("rst_win_valid", 32'(bus.win_valid), 32'd0);
    chk("rst_border", 32'(bus.border), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_pixel", 32'(bus.out_pixel), 32'd0);
    chk("rst_out_x", 32'(bus.out_x), 32'd0);
    chk("rst_out_y", 32'(bus.out_y), 32'd0);
    for (int k = 0; k < 9; k++) chk($sformatf("rst_z%0d", k), 32'(zget(k)), 32'd0);
    reset_n = 1'b1;
    idle(2);
    nout = 0;
    log_q.delete();
    for (int i = 0; i < 4 * W; i++) send(8'd50, i == 0);
    drain();
    chk("flat_count", 32'(nout), 32'd32);
    for (int i = 0; i < log_q.size(); i++) chk("flat_white", 32'(log_q[i]), 32'hff);

    // 2. Window geometry: pix = 10*row + col, stop after (3,5).
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < W; c++)
        if (r < 3 || c <= 5) send(8'(10*r + c), (r == 0) && (c == 0));
    idle(1);
    begin
      int zexp[9] = '{13, 14, 15, 23, 24, 25, 33, 34, 35};
      for (int k = 0; k < 9; k++) chk($sformatf("geom_z%0d", k), 32'(zget(k)), 32'(zexp[k]));
    end
    chk("geom_border", 32'(bus.border), 32'd0);
    drain();

    // 3. Vertical step edge, contiguous.
    log_q.delete();
    for (int i = 0; i < 4 * W; i++) send(((i % W) >= 4) ? 8'd200 : 8'd0, i == 0);
    drain();
    chk("step_count", 32'(log_q.size()), 32'd32);
    for (int i = 0; i < log_q.size(); i++) begin
      int r, c;
      r = i / W;
      c = i % W;
      chk($sformatf("step_r%0d_c%0d", r, c), 32'(log_q[i]),
          (r >= 2 && (c == 4 || c == 5)) ? 32'h00 : 32'hff);
    end
    saved = log_q;

    // 4. Same frame, pix_valid every 3rd cycle.
    log_q.delete();
    for (int i = 0; i < 4 * W; i++) begin
      send(((i % W) >= 4) ? 8'd200 : 8'd0, i == 0);
      idle(2);
    end
    drain();
    chk("gap_count", 32'(log_q.size()), 32'(saved.size()));
    for (int i = 0; i < log_q.size() && i < saved.size(); i++)
      chk("gap_same", 32'(log_q[i]), 32'(saved[i]));

    // 5. Mid-line restart at internal (5,2), random pixels and gaps.
    log_q.delete();
    for (int i = 0; i < 2 * W + 5; i++) send(8'($urandom_range(0, 255)), i == 0);
    send(8'($urandom_range(0, 255)), 1'b1);
    chk("restart_border", 32'(bus.border), 32'd1);
    for (int i = 0; i < 4 * W - 1; i++) begin
      send(8'($urandom_range(0, 255)), 1'b0);
      idle($urandom_range(0, 2));
    end
    drain();
    chk("restart_count", 32'(log_q.size()), 32'(2 * W + 5 + 4 * W));
    for (int i = 0; i < 2 * W; i++)
      if (2 * W + 5 + i < log_q.size())
        chk("restart_white", 32'(log_q[2 * W + 5 + i]), 32'hff);

    // 6. Random frame, reset while outputs are in flight, then restart.
    for (int i = 0; i < 21; i++) begin
      send(8'($urandom_range(0, 255)), i == 0);
      if (i < 18) idle($urandom_range(0, 2));
    end
    reset_n = 1'b0;
    @(posedge clock); #1;
    q.delete();
    ref_col = 0;
    ref_row = 0;
    reset_n = 1'b1;
    chk("rst2_out_valid_0", 32'(bus.out_valid), 32'd0);
    @(posedge clock); #1;
    chk("rst2_out_valid_1", 32'(bus.out_valid), 32'd0);
    @(posedge clock); #1;
    chk("rst2_out_valid_2", 32'(bus.out_valid), 32'd0);
    nout = 0;
    log_q.delete();
    for (int i = 0; i < 5 * W; i++) begin
      send(8'($urandom_range(0, 255)), i == 0);
      idle($urandom_range(0, 2));
    end
    drain();
    chk("rst2_count", 32'(nout), 32'(5 * W));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_window_ctrl.md
Name: sobel_window_ctrl

Overview:
Sequencing controller for the 3x3 Sobel edge datapath. It takes a raster pixel stream, keeps two line buffers, and builds the sliding 3x3 window z0..z8 that feeds the Sobel core. It tracks the core's fixed 3-stage latency so a valid strobe and coordinates line up with the returned edge value. Window positions that touch the first two rows or columns are forced to white (8'hff, "no edge") in the output.

Parameters:
WIDTH, 640, active pixels per line; line-buffer depth and column wrap point
SOBEL_LAT, 3, clock edges from a window update to a valid edge_in
CW, 10, width of the column and row counters and the coordinate outputs

Ports:
clock  input  1  system clock
reset_n  input  1  synchronous active-low reset
pix_in  input  8  greyscale pixel, raster order
pix_valid  input  1  pix_in is accepted this cycle
frame_start  input  1  qualified by pix_valid; marks the pixel as (0,0)
z0..z8  output  8 each  window to the Sobel core; row-major, z0 = top-left, z8 = newest
win_valid  output  1  window was updated at the last edge
border  output  1  current window touches row<2 or col<2
edge_in  input  8  edge_out returned from the Sobel core
out_valid  output  1  out_pixel is valid
out_pixel  output  8  edge result, or 8'hff for border windows
out_x  output  CW  column of the newest pixel in the window for out_pixel
out_y  output  CW  row of the newest pixel in the window for out_pixel

Behaviour:
- Reset (reset_n low at an edge) sets col, row, z0..z8, win_valid, border, the delay line, out_valid, out_pixel, out_x and out_y all to 0. Line-buffer RAM is not cleared; border masking covers stale contents.
- Accepted pixel: pix_valid=1 at an edge. Coordinates (c,r) are (0,0) if frame_start=1; otherwise they are the current col and row.
- On each accepted pixel, in the same edge:
  - shift the window left: z0<=z1, z1<=z2, z3<=z4, z4<=z5, z6<=z7, z7<=z8
  - z2<=lb0[c], z5<=lb1[c], z8<=pix_in
  - lb0[c]<=lb1[c], lb1[c]<=pix_in (read-before-write on the same address)
  - win_valid<=1, border<=(r<2)||(c<2)
- Line buffers: lb1 holds row r-1 and lb0 holds row r-2. Each is WIDTH x 8, and both are read combinationally at c.
- Counter update: if c==WIDTH-1, then col<=0 and row<=r+1, with row saturating at 2^CW-1. Otherwise col<=c+1 and row<=r.
- No pixel accepted: window, col and row hold; win_valid<=0.
- frame_start with pix_valid=0 is ignored. frame_start mid-line abandons the partial line; the next two rows are border-masked.
- Latency matching:
  - The Sobel core is free-running; edge_in reflects the window present SOBEL_LAT edges earlier.
  - {win_valid, border, c, r} go through a SOBEL_LAT-deep shift register that advances every clock, valid or not.
  - Its tap drives out_valid, out_x and out_y. out_pixel is registered as edge_in at that tap cycle, or 8'hff if the delayed border bit is 1.
  - Total latency from accepted pixel to out_valid is SOBEL_LAT+1 edges. One out_valid pulse per accepted pixel; no drops, no throttling.
- Gapped input: gaps propagate unchanged, so out_valid spacing equals pix_valid spacing.
- Reset mid-frame: the pipeline is flushed, no out_valid for 2 cycles after reset release, and the next pixel continues at (0,0) after frame_start.

Test Plan:
1. Reset and flat frame (WIDTH=8, real Sobel core): assert reset_n=0 for 2 cycles with pix_valid toggling → all outputs 0, no out_valid. Then send 4 contiguous rows of value 50 → 32 out_valid pulses, each 4 edges after its pixel; every out_pixel = 8'hff.
2. Window geometry: pix_in = 10*row+col, stop after (r=3,c=5) → z0..z8 = 13,14,15,23,24,25,33,34,35; border=0.
3. Vertical step: rows of 0,0,0,0,200,200,200,200, rows 2..3 checked.
   - Newest col 4 or 5: |Gx|=800 → out_pixel 8'h00.
   - Col 6 or 7: out_pixel 8'hff.
   - Cols 0..1 and rows 0..1: out_pixel 8'hff.
4. Gapped input: repeat scenario 3 with pix_valid every 3rd cycle → identical out_pixel sequence, out_valid spaced 3 apart, out_x/out_y match.
5. Mid-line restart: frame_start with pixel at internal (c=5,r=2) → that pixel reports out_x=0, out_y=0, border=1. Rows 0..1 of the new frame are all 8'hff, and col wraps after 8 pixels.
6. Reset mid-frame: reset_n low for 1 cycle while out_valid pulses are in flight → out_valid=0 for 2 cycles after release, and the next accepted pixel (with frame_start) reports (0,0).
